// File: rtl/tt_uio_bus_arbiter_if.sv
// Requester handshake and uio pin bundle shared by the arbiter and the
// blocks that request the pins.
interface tt_uio_bus_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_dir;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*8-1:0] req_data;
  logic [7:0]        uio_in;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              busy;

  // Requester / pad side: raises requests and supplies pin input.
  modport master (
    output req, req_dir, req_last, req_data, uio_in,
    input  gnt, uio_out, uio_oe, rd_data, rd_valid, busy
  );

  // Arbiter side: owns grants and the pin output path.
  modport slave (
    input  req, req_dir, req_last, req_data, uio_in,
    output gnt, uio_out, uio_oe, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/tt_uio_bus_arbiter.sv
// Round-robin arbiter for the 8 shared uio pins. One requester owns the pins
// at a time, either driving them or sampling them; drive grants are followed
// by TURN idle cycles with the output enables off so that an off-chip driver
// and the chip never fight over the pins.
module tt_uio_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TURN    = 2,
  parameter int MAXHOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_uio_bus_arbiter_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
  localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'((TURN > 0) ? TURN - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] owner_reg, owner_next;
  logic          dir_reg, dir_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic [TW-1:0] turn_reg, turn_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [7:0]    uio_out_reg, uio_out_next;
  logic [7:0]    uio_oe_reg, uio_oe_next;
  logic [7:0]    rd_data_reg, rd_data_next;
  logic          rd_valid_reg, rd_valid_next;

  logic [7:0]      data_lane [NREQ];
  logic [NREQ-1:0] owner_mask;
  logic [PW-1:0]   pick;
  logic            pick_valid;
  logic            owner_req, owner_last, others_waiting, release_now;
  logic [PW-1:0]   owner_inc;

  // Per-requester byte lanes and a one-hot mask of the current owner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign data_lane[gi]  = bus.req_data[8*gi +: 8];
    assign owner_mask[gi] = (owner_reg == PW'(gi));
  end

  assign owner_req      = |(bus.req & owner_mask);
  assign owner_last     = |(bus.req_last & owner_mask);
  assign others_waiting = |(bus.req & ~owner_mask);
  assign release_now    = !owner_req || owner_last ||
                          ((hold_reg == HOLD_LAST) && others_waiting);
  assign owner_inc      = (owner_reg == PW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;

  // First requesting index scanning ptr, ptr+1, ... modulo NREQ; iterating
  // downwards lets the closest-to-ptr candidate win the last assignment.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    pick       = '0;
    pick_valid = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_reg} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      cand = sum[PW-1:0];
      if (bus.req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // State and output registers; reset wins from any state with no turnaround.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= '0;
      dir_reg      <= 1'b0;
      ptr_reg      <= '0;
      hold_reg     <= '0;
      turn_reg     <= '0;
      gnt_reg      <= '0;
      uio_out_reg  <= 8'h00;
      uio_oe_reg   <= 8'h00;
      rd_data_reg  <= 8'h00;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      dir_reg      <= dir_next;
      ptr_reg      <= ptr_next;
      hold_reg     <= hold_next;
      turn_reg     <= turn_next;
      gnt_reg      <= gnt_next;
      uio_out_reg  <= uio_out_next;
      uio_oe_reg   <= uio_oe_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, release from GRANT, count TURN.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    dir_next   = dir_reg;
    ptr_next   = ptr_reg;
    hold_next  = hold_reg;
    turn_next  = turn_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next = ST_GRANT;
          owner_next = pick;
          dir_next   = bus.req_dir[pick];
          hold_next  = '0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          ptr_next   = owner_inc;
          turn_next  = '0;
          state_next = (dir_reg && (TURN > 0)) ? ST_TURN : ST_IDLE;
        end else if (hold_reg != HOLD_LAST) begin
          hold_next = hold_reg + 1'b1;
        end
      end
      ST_TURN: begin
        if (turn_reg == TURN_LAST) state_next = ST_IDLE;
        else                       turn_next  = turn_reg + 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered pin, grant and sample outputs.
  always_comb begin
    gnt_next      = '0;
    uio_oe_next   = 8'h00;
    uio_out_next  = uio_out_reg;
    rd_data_next  = rd_data_reg;
    rd_valid_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_next[pick] = 1'b1;
          if (bus.req_dir[pick]) begin
            uio_oe_next  = 8'hFF;
            uio_out_next = data_lane[pick];
          end
        end
      end
      ST_GRANT: begin
        if (dir_reg) begin
          uio_out_next = data_lane[owner_reg];
        end else begin
          rd_data_next  = bus.uio_in;
          rd_valid_next = 1'b1;
        end
        if (!release_now) begin
          gnt_next    = gnt_reg;
          uio_oe_next = dir_reg ? 8'hFF : 8'h00;
        end
      end
      default: ;
    endcase
  end

  assign bus.gnt      = gnt_reg;
  assign bus.uio_out  = uio_out_reg;
  assign bus.uio_oe   = uio_oe_reg;
  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.busy     = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_tt_uio_bus_arbiter.sv
// Bench for tt_uio_bus_arbiter: a vector table for the basic drive and
// round-robin flows, hand-written sequences for reset, sampling, hold-limit
// preemption and owner drop, then random traffic against a reference model.
`timescale 1ns/1ps
module tb_tt_uio_bus_arbiter;
  localparam int NREQ    = 4;
  localparam int TURN    = 2;
  localparam int MAXHOLD = 16;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  tt_uio_bus_arbiter_if #(.NREQ(NREQ)) bus();

  tt_uio_bus_arbiter #(.NREQ(NREQ), .TURN(TURN), .MAXHOLD(MAXHOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_last = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (rule level, not state encoded) -------
  int         m_owner;   // -1 when nobody owns the pins
  int         m_dir;
  int         m_held;    // grant cycles already completed by the owner
  int         m_gap;     // idle cycles still to pass before arbitration
  int         m_ptr;
  logic [7:0] m_out, m_rd;
  logic       m_rdv;

  task automatic model_step();
    bit was_sample;
    bit others;
    int c;
    if (!rst_n) begin
      m_owner = -1; m_dir = 0; m_held = 0; m_gap = 0; m_ptr = 0;
      m_out = 8'h00; m_rd = 8'h00; m_rdv = 1'b0;
      return;
    end
    was_sample = (m_owner >= 0) && (m_dir == 0);
    if (m_owner >= 0) begin
      others = 0;
      for (int i = 0; i < NREQ; i++) if (i != m_owner && bus.req[i]) others = 1;
      if (m_dir != 0) m_out = bus.req_data[8*m_owner +: 8];
      else            m_rd  = bus.uio_in;
      if (!bus.req[m_owner] || bus.req_last[m_owner] ||
          (m_held >= MAXHOLD - 1 && others)) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_gap   = (m_dir != 0) ? TURN : 0;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (bus.req[c]) begin
          m_owner = c;
          m_dir   = int'(bus.req_dir[c]);
          m_held  = 0;
          if (m_dir != 0) m_out = bus.req_data[8*c +: 8];
          break;
        end
      end
    end
    m_rdv = was_sample;
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_n;
    logic [3:0] req, dir, last;
    logic [7:0] uio;
    logic [3:0] gnt;
    logic [7:0] oe, out;
    logic       rdv;
    logic [7:0] rd;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, dr, ls,
                              input logic [7:0] ui, input logic [3:0] g,
                              input logic [7:0] oe, ot, input logic rv,
                              input logic [7:0] rd, input logic b);
    vec_t v;
    v.rst_n = r; v.req = rq; v.dir = dr; v.last = ls; v.uio = ui;
    v.gnt = g; v.oe = oe; v.out = ot; v.rdv = rv; v.rd = rd; v.busy = b;
    return v;
  endfunction

  int n;
  int m;
  bit stay_ok;
  logic [3:0] prev_gnt;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req = '0; bus.req_dir = '0; bus.req_last = '0;
    bus.req_data = 32'h44_33_A5_11;
    bus.uio_in = 8'h00;

    // reset, single drive of 0xA5 by requester 1 with TURN gap, drop
    vt.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 0));
    vt.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 0));
    vt.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 8'h00, 4'b0010, 8'hFF, 8'hA5, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 8'h00, 4'b0010, 8'hFF, 8'hA5, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 8'h00, 4'b0010, 8'hFF, 8'hA5, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b0010, 4'b0010, 4'b0010, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 0));
    vt.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 8'h00, 4'b0010, 8'hFF, 8'hA5, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b0000, 4'b0010, 4'b0000, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b0000, 4'b0010, 4'b0000, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b0000, 4'b0010, 4'b0000, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 0));
    // reset in IDLE clears uio_out and the rotation pointer
    vt.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 0));
    // round robin over four sample requesters, one beat each
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 8'h10, 4'b0001, 8'h00, 8'h00, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 8'h21, 4'b0000, 8'h00, 8'h00, 1, 8'h21, 0));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 8'h32, 4'b0010, 8'h00, 8'h00, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 8'h43, 4'b0000, 8'h00, 8'h00, 1, 8'h43, 0));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 8'h54, 4'b0100, 8'h00, 8'h00, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 8'h65, 4'b0000, 8'h00, 8'h00, 1, 8'h65, 0));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 8'h76, 4'b1000, 8'h00, 8'h00, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 8'h87, 4'b0000, 8'h00, 8'h00, 1, 8'h87, 0));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 8'h98, 4'b0001, 8'h00, 8'h00, 0, 8'h00, 1));
    vt.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 8'hA9, 4'b0000, 8'h00, 8'h00, 1, 8'hA9, 0));
    vt.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 8'hBA, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 0));

    foreach (vt[i]) begin
      rst_n = vt[i].rst_n;
      bus.req = vt[i].req; bus.req_dir = vt[i].dir;
      bus.req_last = vt[i].last; bus.uio_in = vt[i].uio;
      cyc();
      $display("[TB] vec %0d: gnt=%b oe=%h out=%h rdv=%b rd=%h busy=%b", i,
               bus.gnt, bus.uio_oe, bus.uio_out, bus.rd_valid, bus.rd_data, bus.busy);
      chk($sformatf("vec%0d gnt", i), bus.gnt, vt[i].gnt);
      chk($sformatf("vec%0d oe", i), bus.uio_oe, vt[i].oe);
      chk($sformatf("vec%0d rd_valid", i), bus.rd_valid, vt[i].rdv);
      chk($sformatf("vec%0d busy", i), bus.busy, vt[i].busy);
      if (vt[i].oe == 8'hFF || !vt[i].rst_n)
        chk($sformatf("vec%0d uio_out", i), bus.uio_out, vt[i].out);
      if (vt[i].rdv || !vt[i].rst_n)
        chk($sformatf("vec%0d rd_data", i), bus.rd_data, vt[i].rd);
    end

    // reset during a drive grant: outputs drop on the first reset edge
    do_reset();
    bus.req = 4'b0100; bus.req_dir = 4'b0100; bus.req_last = '0;
    cyc();
    chk("rst pre gnt", bus.gnt, 4'b0100);
    chk("rst pre oe", bus.uio_oe, 8'hFF);
    chk("rst pre out", bus.uio_out, 8'h33);
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("rst gnt", bus.gnt, 4'b0000);
    chk("rst oe", bus.uio_oe, 8'h00);
    chk("rst out", bus.uio_out, 8'h00);
    chk("rst rd_valid", bus.rd_valid, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    cyc();
    chk("rst2 busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk("rst no turnaround gnt", bus.gnt, 4'b0100);
    bus.req = '0;
    cyc();
    chk("rst drop busy", bus.busy, 1'b1);
    cyc();
    cyc();
    chk("rst drop idle", bus.busy, 1'b0);
    $display("[TB] seq reset-mid-drive done");

    // sample grant for requester 3
    do_reset();
    bus.req = 4'b1000; bus.req_dir = 4'b0000; bus.uio_in = 8'h3C;
    cyc();
    chk("smp gnt", bus.gnt, 4'b1000);
    chk("smp rdv first", bus.rd_valid, 1'b0);
    cyc();
    chk("smp rdv", bus.rd_valid, 1'b1);
    chk("smp rd 3C", bus.rd_data, 8'h3C);
    chk("smp oe", bus.uio_oe, 8'h00);
    bus.uio_in = 8'hC3;
    cyc();
    chk("smp rd C3", bus.rd_data, 8'hC3);
    bus.uio_in = 8'h5E; bus.req_last = 4'b1000;
    cyc();
    chk("smp last gnt", bus.gnt, 4'b0000);
    chk("smp last rdv", bus.rd_valid, 1'b1);
    chk("smp last rd", bus.rd_data, 8'h5E);
    bus.req = '0; bus.req_last = '0;
    cyc();
    chk("smp end rdv", bus.rd_valid, 1'b0);
    $display("[TB] seq sample done");

    // hold limit: requester 0 drives, requester 2 arrives on grant cycle 5
    do_reset();
    bus.req_data[7:0] = 8'hC7;
    bus.req = 4'b0001; bus.req_dir = 4'b0001;
    cyc();
    n = 0;
    while (bus.gnt == 4'b0001 && n < 100) begin
      n++;
      if (n == 3) chk("hold out", bus.uio_out, 8'hC7);
      if (n == 5) bus.req[2] = 1'b1;
      cyc();
    end
    chk("hold grant length", n, MAXHOLD);
    m = 0;
    while (bus.gnt == 4'b0000 && m < 20) begin
      chk("hold gap oe", bus.uio_oe, 8'h00);
      m++;
      cyc();
    end
    chk("hold gap length", m, TURN + 1);
    chk("hold next gnt", bus.gnt, 4'b0100);
    bus.req_last = 4'b0100;
    cyc();
    bus.req[2] = 1'b0; bus.req_last = '0;
    cyc();
    chk("hold regrant", bus.gnt, 4'b0001);
    stay_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.gnt != 4'b0001 || bus.uio_oe != 8'hFF) stay_ok = 1'b0;
      cyc();
    end
    chk("hold alone stays", stay_ok, 1'b1);
    $display("[TB] seq maxhold done");

    // owner drop mid-drive moves ptr past the owner
    do_reset();
    bus.req = 4'b0100; bus.req_dir = 4'b0100;
    cyc();
    cyc();
    bus.req = 4'b0000;
    cyc();
    chk("drop oe", bus.uio_oe, 8'h00);
    chk("drop gnt", bus.gnt, 4'b0000);
    chk("drop busy", bus.busy, 1'b1);
    bus.req = 4'b1001; bus.req_dir = 4'b0000;
    n = 0;
    while (bus.gnt == 4'b0000 && n < 10) begin
      n++;
      cyc();
    end
    chk("drop wait", n, TURN + 1);
    chk("drop ptr order", bus.gnt, 4'b1000);
    bus.req_last = 4'b1000;
    cyc();
    bus.req = '0; bus.req_last = '0;
    cyc();
    $display("[TB] seq owner-drop done");

    // random traffic against the reference model
    prev_gnt = '0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = (c == 0 || $urandom_range(299) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(11) == 0) bus.req[i] = ~bus.req[i];
        bus.req_dir[i]  = 1'($urandom_range(1));
        bus.req_last[i] = ($urandom_range(15) == 0);
      end
      bus.req_data = 32'($urandom);
      bus.uio_in   = 8'($urandom);
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rnd%0d gnt", c), bus.gnt, m_gnt());
      chk($sformatf("rnd%0d oe", c), bus.uio_oe,
          (m_owner >= 0 && m_dir != 0) ? 8'hFF : 8'h00);
      chk($sformatf("rnd%0d busy", c), bus.busy, (m_owner >= 0 || m_gap > 0));
      chk($sformatf("rnd%0d rd_valid", c), bus.rd_valid, m_rdv);
      chk($sformatf("rnd%0d onehot", c), $onehot0(bus.gnt), 1'b1);
      if (bus.uio_oe == 8'hFF)
        chk($sformatf("rnd%0d uio_out", c), bus.uio_out, m_out);
      if (m_rdv)
        chk($sformatf("rnd%0d rd_data", c), bus.rd_data, m_rd);
      if (bus.gnt != 4'b0000 && prev_gnt == 4'b0000)
        $display("[TB] rnd cycle %0d: grant %b dir %0d", c, bus.gnt, m_dir);
      prev_gnt = bus.gnt;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
